demux_route_scheduler: RTL

- Sequencing controller for the 64-way 1-bit demultiplexer tree.
- Accepts {data bit, destination} items over a valid/ready handshake and buffers them in a small FIFO.
- Drives the tree's din/sel pair one item at a time, holding each for a programmable number of cycles.
- Supports directed routing, or a round-robin sweep over enabled channels, with per-channel masking.

---
 rtl/demux_route_if.sv | 30 +++
 rtl/demux_route_scheduler.sv | 107 ++++++++++
 2 files changed

// File: rtl/demux_route_if.sv
// demux_route_if: item handshake and demux-tree drive bundle for demux_route_scheduler
// master drives items, mode and mask; slave is the scheduler producing sel/din/valid/busy.
// drop_cnt exists only when SCHED_STATS_EN is defined.
interface demux_route_if #(
  parameter int NCH  = 64,
  parameter int SELW = 6
);
  logic            in_valid;
  logic            in_ready;
  logic            in_data;
  logic [SELW-1:0] in_dest;
  logic            mode;
  logic [NCH-1:0]  ch_mask;
  logic [SELW-1:0] out_sel;
  logic            out_din;
  logic            out_valid;
  logic            busy;
`ifdef SCHED_STATS_EN
  logic [7:0]      drop_cnt;
  modport master (output in_valid, in_data, in_dest, mode, ch_mask,
                  input in_ready, out_sel, out_din, out_valid, busy, drop_cnt);
  modport slave  (input in_valid, in_data, in_dest, mode, ch_mask,
                  output in_ready, out_sel, out_din, out_valid, busy, drop_cnt);
`else
  modport master (output in_valid, in_data, in_dest, mode, ch_mask,
                  input in_ready, out_sel, out_din, out_valid, busy);
  modport slave  (input in_valid, in_data, in_dest, mode, ch_mask,
                  output in_ready, out_sel, out_din, out_valid, busy);
`endif
endinterface

// File: rtl/demux_route_scheduler.sv
// demux_route_scheduler: FIFO-buffered sequencer driving the 1-bit demux tree's din/sel
// Ports: clk, rst_n (async active-low), bus (demux_route_if.slave):
//   in_valid/in_ready/in_data/in_dest item handshake, mode (0 directed, 1 sweep),
//   ch_mask channel enables, out_sel/out_din/out_valid tree drive, busy,
//   drop_cnt saturating drop counter when SCHED_STATS_EN is defined.
module demux_route_scheduler #(
  parameter int NCH   = 64,
  parameter int SELW  = 6,
  parameter int DEPTH = 4,
  parameter int HOLD  = 1
) (
  input logic           clk,
  input logic           rst_n,
  demux_route_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  state_t          state_q, state_d;
  logic [SELW:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [SELW-1:0] ptr_q, ptr_d, sel_q, sel_d, off, ch;
  logic [HW-1:0]   hold_q, hold_d;
  logic            din_q, din_d, vld_q, vld_d;
  logic            push, pop, hit, full, empty;
  logic [SELW:0]   head;
`ifdef SCHED_STATS_EN
  logic [7:0]      drop_q, drop_d;
  assign bus.drop_cnt = drop_q;
`endif
  assign full          = cnt_q == (AW+1)'(DEPTH);
  assign empty         = cnt_q == '0;
  assign head          = mem_q[rd_q];
  assign bus.in_ready  = rst_n && !full;
  assign bus.out_sel   = sel_q;
  assign bus.out_din   = din_q;
  assign bus.out_valid = vld_q;
  assign bus.busy      = !empty || state_q != IDLE;
  always_comb begin
    // Lowest enabled offset from ptr; the descending loop lets smaller offsets win.
    off = '0;
    for (int i = NCH - 1; i >= 0; i--) off = bus.ch_mask[ptr_q + SELW'(i)] ? SELW'(i) : off;
    ch      = bus.mode ? ptr_q + off : head[SELW-1:0];
    hit     = bus.mode ? |bus.ch_mask : bus.ch_mask[head[SELW-1:0]];
    push    = bus.in_valid && bus.in_ready;
    pop     = state_q == IDLE && !empty;
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    din_d   = din_q;
    vld_d   = vld_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (pop && hit) begin
        state_d = DRIVE;
        sel_d   = ch;
        din_d   = head[SELW];
        vld_d   = 1'b1;
        hold_d  = HW'(HOLD - 1);
        ptr_d   = bus.mode ? ch + SELW'(1) : ptr_q;
      end
      DRIVE: if (hold_q == '0) begin
        state_d = GAP;
        vld_d   = 1'b0;
        din_d   = 1'b0;
      end else hold_d = hold_q - HW'(1);
      default: state_d = IDLE;
    endcase
`ifdef SCHED_STATS_EN
    drop_d = (pop && !hit && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
`endif
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= {bus.in_data, bus.in_dest};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      din_q   <= 1'b0;
      vld_q   <= 1'b0;
      hold_q  <= '0;
`ifdef SCHED_STATS_EN
      drop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      din_q   <= din_d;
      vld_q   <= vld_d;
      hold_q  <= hold_d;
`ifdef SCHED_STATS_EN
      drop_q  <= drop_d;
`endif
    end
  end
endmodule
